mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Sub-word load/store controller between the MIPS datapath and the word-only data memory (`dmem`). It accepts byte, halfword and word requests. It performs sign or zero extension on loads. It implements sub-word stores as a read-modify-write sequence, because the data memory has only whole-word, write-enabled storage with a combinational read port. A busy signal stalls the pipeline while an access is in flight, and alignment faults are flagged without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width (memory side always word-aligned)

Ports:
- `clock`  in  1  rising-edge clock for all state
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  1  access request; sampled only when `busy`=0
- `we`  in  1  1=store, 0=load (qualified by `req`)
- `size`  in  2  00=byte, 01=halfword, 10=word, 11=reserved
- `sign_ext`  in  1  loads only: 1=sign-extend, 0=zero-extend
- `addr`  in  ADDR_W  byte address
- `wdata`  in  32  store data, right-justified for byte and halfword sizes
- `busy`  out  1  high while an accepted access is in flight
- `done`  out  1  one-cycle completion pulse (also pulses on fault)
- `misaligned`  out  1  one-cycle fault pulse, coincident with `done`
- `rdata`  out  32  extended load result; holds until the next load completes
- `mem_addr`  out  ADDR_W  word address to dmem, {addr[ADDR_W-1:2],2'b00}
- `mem_we`  out  1  dmem write enable
- `mem_wd`  out  32  dmem write data
- `mem_rd`  in  32  dmem combinational read data

## Operation
- Byte order is big-endian.
  - Byte offset 0 maps to `mem_rd[31:24]`.
  - Halfword offset 0 maps to `[31:16]`.
- Alignment rules:
  - A halfword is misaligned when `addr[0]`=1.
  - A word is misaligned when `addr[1:0]`≠0.
  - `size`=11 is always a fault.
- FSM states: IDLE, LOAD, WRITE, RMW_RD, RMW_WR.
- IDLE with `req`=1, on the next edge:
  - Faulting request → stay in IDLE; pulse `done` and `misaligned`; no memory access.
  - Load → LOAD.
  - Word store → WRITE.
  - Byte or halfword store → RMW_RD.
  - The edge latches `addr`, `size`, `sign_ext` and `wdata` internally; the inputs may change afterwards.
- LOAD:
  - Extract the lane from `mem_rd`, extend it, and register it into `rdata`.
  - Set `done`=1 and go to IDLE.
- WRITE: `mem_we`=1, `mem_wd`=latched `wdata`; set `done`=1 and go to IDLE.
- RMW_RD: register `mem_rd` into the merge register and go to RMW_WR.
- RMW_WR:
  - `mem_we`=1.
  - `mem_wd` = merge register with the addressed lane replaced by the low 8 or 16 bits of the latched `wdata`.
  - Set `done`=1 and go to IDLE.
- `mem_we` is decoded from the registered state only and is never combinational from `req`.
- `mem_addr` outputs the latched word address in all non-IDLE states and 0 in IDLE.
- `busy` = (state ≠ IDLE).
- While `busy`=1, `req` is ignored; the master holds its request until `busy` falls.
- A new request may be accepted in the same cycle that `done` is high (back-to-back).
- Reset (asynchronous, any state):
  - state=IDLE.
  - `busy`, `done`, `misaligned`, `mem_we` = 0.
  - `rdata`, `mem_addr`, `mem_wd`, merge register = 0.
  - A reset asserted mid-RMW aborts before the write edge, leaving memory unchanged.

## Timing
- All latencies are counted from the accepting edge E0.
- Load:
  - LOAD during cycle 1.
  - `done` and valid `rdata` in cycle 2.
  - `busy` for 1 cycle.
- Word store:
  - WRITE in cycle 1; memory is updated at edge E1.
  - `done` in cycle 2.
- Sub-word store:
  - RMW_RD in cycle 1, RMW_WR in cycle 2; memory is updated at edge E2.
  - `done` in cycle 3.
  - `busy` for 2 cycles.
- Fault: `done` and `misaligned` in cycle 1; `busy` never rises.
- `done` and `misaligned` are registered pulses, exactly one cycle wide.

## Structure
- `mem_pkg` holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state encoding;
  - an alignment-check function shared with the decode stage.
- Sub-module `byte_lane` (combinational) provides:
  - lane extract plus sign/zero extension for loads;
  - lane merge for stores, selected by `size` and `addr[1:0]`.
- The top level holds the FSM, the request latches, the merge register and the output registers.

## Test plan
- Load all sizes: with word 0x80F1_7F02 at address 0x10:
  - lb 0x10, sign_ext=1 → `rdata`=0xFFFF_FF80 in cycle 2.
  - lbu 0x13 → 0x0000_0002.
  - lh 0x12 → 0x0000_7F02.
  - lhu 0x10 → 0x0000_80F1.
- Byte store: sb 0xAB to 0x11 over 0x1122_3344 → `mem_we` only in cycle 2 with `mem_wd`=0x11AB_3344; `done` in cycle 3; `busy` high for 2 cycles.
- Halfword and word stores: sh 0xBEEF to 0x22 over 0 → memory = 0x0000_BEEF; sw 0xDEAD_BEEF to 0x24 → `mem_we` in cycle 1 with `done` in cycle 2.
- Faults: lh 0x01, sw 0x06 and size=11 → `done`+`misaligned` in cycle 1, `mem_we` never asserted, memory unchanged.
- Back-to-back and hold: issue a new `req` in the `done` cycle; it is accepted with no gap. A `req` pulsed while `busy` is ignored.
- Reset abort: assert `reset_n`=0 during RMW_RD of an sb → outputs clear immediately and the target word is unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states and the alignment check shared with decode.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_RMW_RD, ST_RMW_WR} state_t;

    // Reserved size 2'b11 always faults.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF) ? off[0] :
               (size == SZ_WORD) ? (off != 2'b00) : (size != SZ_BYTE);
    endfunction
endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// byte_lane: big-endian lane extract/extend for loads and lane merge for stores.
module byte_lane
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] lane;
    logic        msb;

    always_comb begin
        // Offset 0 is the most significant lane, hence the inverted offset.
        sh         = (size == SZ_BYTE) ? {~off, 3'b000} :
                     (size == SZ_HALF) ? {~off[1], 4'b0000} : 5'd0;
        mask       = (size == SZ_BYTE) ? 32'h0000_00FF :
                     (size == SZ_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        lane       = (word >> sh) & mask;
        msb        = (size == SZ_BYTE) ? lane[7] : lane[15];
        load_data  = (size == SZ_WORD) ? word : (lane | ({32{sign_ext & msb}} & ~mask));
        merge_data = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store controller over a word-only dmem,
// with read-modify-write for sub-word stores and alignment fault reporting.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic [31:0]       load_data, merge_data;

    byte_lane u_lane (
        .size       (size_q),
        .off        (addr_q[1:0]),
        .sign_ext   (sext_q),
        .word       ((state_q == ST_LOAD) ? mem_rd : merge_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: if (req) begin
                addr_d  = addr;
                size_d  = size;
                sext_d  = sign_ext;
                wdata_d = wdata;
                if (is_misaligned(size, addr[1:0])) begin
                    done_d = 1'b1;
                    mis_d  = 1'b1;
                end else begin
                    state_d = !we ? ST_LOAD : (size == SZ_WORD) ? ST_WRITE : ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                rdata_d = load_data;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RMW_RD: begin
                merge_d = mem_rd;
                state_d = ST_RMW_WR;
            end
            default: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign misaligned = mis_q;
    assign rdata      = rdata_q;
    assign mem_we     = (state_q == ST_WRITE) || (state_q == ST_RMW_WR);
    assign mem_addr   = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wd     = (state_q == ST_WRITE) ? wdata_q :
                        (state_q == ST_RMW_WR) ? merge_data : 32'h0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-array big-endian memory model.
module tb_mem_access_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, misaligned, mem_we;
    logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

    logic [31:0] dmem [0:63];
    logic [7:0]  rm [0:255];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          cyc = 0;
    int          total = 0, passed = 0;
    logic [31:0] last_rd = '0;

    typedef struct {
        logic        is_load;
        logic        mis;
        logic [31:0] rd;
        logic [5:0]  widx;
        logic [31:0] mword;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .misaligned(misaligned), .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign mem_rd = dmem[mem_addr[7:2]];
    always @(posedge clock) begin
        if (mem_we) dmem[mem_addr[7:2]] <= mem_wd;
        else if (pl_en) dmem[pl_idx] <= pl_val;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_word(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) rm[{a[7:2], 2'b00} + i] = 8'(w >> (8 * (3 - i)));
        pl_en = 1'b1; pl_idx = a[7:2]; pl_val = w;
        @(posedge clock); #1 pl_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 50) begin @(negedge clock); n++; end
        check("drain", 32'(q.size()), 32'd0);
        @(negedge clock);
    endtask

    // Model: memory as a byte array, access of n bytes starting at addr, MSB first.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [7:0] a,
                         input logic [31:0] wd, input logic commit, output logic bb);
        exp_t e;
        int n, wn;
        logic [31:0] v;
        logic [7:0] base;
        wn = 0;
        @(negedge clock);
        while (busy && wn < 20) begin @(negedge clock); wn++; end
        check("issue_wait", {31'b0, busy}, 32'd0);
        bb = done;
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = {24'b0, a}; wdata = wd;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.mis = (sz == 2'd3) || ((int'(a) % n) != 0);
        e.is_load = !w && !e.mis;
        v = 0;
        if (e.is_load) begin
            for (int i = 0; i < n; i++) v = (v << 8) | {24'b0, rm[int'(a) + i]};
            if (n < 4 && sx && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        end
        if (!e.mis && w && commit)
            for (int i = 0; i < n; i++) rm[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
        base = {a[7:2], 2'b00};
        e.rd = v;
        e.widx = a[7:2];
        e.mword = {rm[base], rm[base + 1], rm[base + 2], rm[base + 3]};
        e.acc = cyc;
        e.lat = e.mis ? 1 : !w ? 2 : (sz == 2'd2) ? 2 : 3;
        if (commit) q.push_back(e);
        @(posedge clock); #1 req = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (misaligned && !done) check("mis_without_done", 32'd1, 32'd0);
            if (done) begin
                if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    mon_e = q.pop_front();
                    check("misaligned", {31'b0, misaligned}, {31'b0, mon_e.mis});
                    check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    if (mon_e.is_load) last_rd = mon_e.rd;
                    check("rdata", rdata, last_rd);
                    check("mem_word", dmem[mon_e.widx], mon_e.mword);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic bb;
        for (int i = 0; i < 64; i++) set_word(8'(i * 4), $urandom);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {30'b0, done, misaligned}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        @(negedge clock); reset_n = 1'b1;

        set_word(8'h10, 32'h80F1_7F02);
        issue(1'b0, 2'd0, 1'b1, 8'h10, 32'h0, 1'b1, bb);
        issue(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 1'b1, bb);
        check("back_to_back", {31'b0, bb}, 32'd1);
        issue(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, 1'b1, bb);
        issue(1'b0, 2'd1, 1'b0, 8'h10, 32'h0, 1'b1, bb);
        drain();

        set_word(8'h10, 32'h1122_3344);
        issue(1'b1, 2'd0, 1'b0, 8'h11, 32'h0000_00AB, 1'b1, bb);
        check("sb_c1_we", {31'b0, mem_we}, 32'd0);
        check("sb_c1_busy", {31'b0, busy}, 32'd1);
        check("sb_c1_addr", mem_addr, 32'h10);
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'hFFFF_FFFF;
        @(posedge clock); #1 req = 1'b0;
        check("sb_c2_we", {31'b0, mem_we}, 32'd1);
        check("sb_c2_wd", mem_wd, 32'h11AB_3344);
        check("sb_c2_busy", {31'b0, busy}, 32'd1);
        @(posedge clock); #1;
        check("sb_c3_busy", {31'b0, busy}, 32'd0);
        check("sb_c3_done", {31'b0, done}, 32'd1);
        drain();

        set_word(8'h20, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 8'h22, 32'h0000_BEEF, 1'b1, bb);
        issue(1'b1, 2'd2, 1'b0, 8'h24, 32'hDEAD_BEEF, 1'b1, bb);
        check("sw_c1_we", {31'b0, mem_we}, 32'd1);
        check("sw_c1_wd", mem_wd, 32'hDEAD_BEEF);
        check("sw_c1_addr", mem_addr, 32'h24);
        @(posedge clock); #1;
        check("sw_c2_we", {31'b0, mem_we}, 32'd0);
        drain();

        issue(1'b0, 2'd1, 1'b1, 8'h01, 32'h0, 1'b1, bb);
        check("lh_fault_c1", {busy, mem_we, done, misaligned}, 32'h3);
        issue(1'b1, 2'd2, 1'b0, 8'h06, 32'h1234_5678, 1'b1, bb);
        check("sw_fault_c1", {busy, mem_we, done, misaligned}, 32'h3);
        issue(1'b0, 2'd3, 1'b0, 8'h20, 32'h0, 1'b1, bb);
        check("sz3_fault_c1", {busy, mem_we, done, misaligned}, 32'h3);
        drain();

        set_word(8'h30, 32'h1122_3344);
        issue(1'b1, 2'd0, 1'b0, 8'h31, 32'h0000_00AB, 1'b0, bb);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_we", {31'b0, mem_we}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_wd", mem_wd, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        last_rd = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 8'h30, 32'h0, 1'b1, bb);
        drain();

        for (int k = 0; k < 300; k++)
            issue(1'($urandom), ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3),
                  1'($urandom), 8'($urandom), $urandom, 1'b1, bb);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
